// File: rtl/vec_mem_stage.sv
// Vector MEM stage: serializes per-lane loads/stores onto one word port and registers the MEM/WB boundary.
// Define VMEM_LANE_MASK_EN to add LaneMaskM so only enabled lanes are accessed.
module vec_mem_stage #(
    parameter int LANES  = 16,
    parameter int DATA_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [LANES-1:0][DATA_W-1:0] ALUResultM,
    input  logic [LANES-1:0][DATA_W-1:0] WriteDataM,
    input  logic                         RegWriteM,
    input  logic                         MemtoRegM,
    input  logic                         MemWriteM,
    input  logic [3:0]                   WA3M,
`ifdef VMEM_LANE_MASK_EN
    input  logic [LANES-1:0]             LaneMaskM,
`endif
    output logic                         StallM,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [DATA_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic [LANES-1:0][DATA_W-1:0] ALUResultW,
    output logic [LANES-1:0][DATA_W-1:0] ReadDataW,
    output logic                         RegWriteW,
    output logic                         MemtoRegW,
    output logic [3:0]                   WA3W
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] wa3;
    } wb_ctl_t;

    state_t                       state_q, state_d;
    logic [LW-1:0]                lane_q, lane_d;
    logic                         store_q, store_d;
    logic [LANES-1:0][DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [LANES-1:0][DATA_W-1:0] alu_w_q, alu_w_d, rd_w_q, rd_w_d;
    wb_ctl_t                      ctl_q, ctl_d, wctl_q, wctl_d, ctl_m;
    logic                         mem_op;

    assign mem_op = MemtoRegM | MemWriteM;
    assign ctl_m  = {RegWriteM, MemtoRegM, WA3M};

`ifdef VMEM_LANE_MASK_EN
    logic [LANES-1:0] mask_q, mask_d;
    logic [LW:0]      first_m, next_m;

    // {found, lane} of the lowest set mask bit at or above 'from'
    function automatic logic [LW:0] next_set(input logic [LANES-1:0] m, input int from);
        logic [LW:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (m[i] && i >= from) r = {1'b1, LW'(i)};
        return r;
    endfunction

    assign first_m = next_set(LaneMaskM, 0);
    assign next_m  = next_set(mask_q, int'(lane_q) + 1);
`endif

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        store_d   = store_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        ctl_d     = ctl_q;
        alu_w_d   = alu_w_q;
        rd_w_d    = rd_w_q;
        wctl_d    = wctl_q;
`ifdef VMEM_LANE_MASK_EN
        mask_d    = mask_q;
`endif
        StallM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    StallM  = 1'b1;
                    addr_d  = ALUResultM;
                    wdata_d = WriteDataM;
                    store_d = MemWriteM;
                    ctl_d   = ctl_m;
                    lane_d  = '0;
                    wctl_d  = '0;
                    state_d = ACCESS;
`ifdef VMEM_LANE_MASK_EN
                    // masked lanes must read back as zero
                    mask_d  = LaneMaskM;
                    buf_d   = '0;
                    if (first_m[LW]) lane_d = first_m[LW-1:0];
                    else             state_d = DONE;
`endif
                end else begin
                    alu_w_d = ALUResultM;
                    rd_w_d  = '0;
                    wctl_d  = ctl_m;
                end
            end
            ACCESS: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = addr_q[lane_q];
                mem_wdata = wdata_q[lane_q];
                if (mem_ack) begin
                    if (!store_q) buf_d[lane_q] = mem_rdata;
`ifdef VMEM_LANE_MASK_EN
                    if (next_m[LW]) lane_d = next_m[LW-1:0];
                    else            state_d = DONE;
`else
                    if (lane_q == LW'(LANES - 1)) state_d = DONE;
                    else                          lane_d = lane_q + 1'b1;
`endif
                end
            end
            DONE: begin
                // upstream still holds the op, so ALUResultM is the op's result
                alu_w_d = ALUResultM;
                rd_w_d  = store_q ? '0 : buf_q;
                wctl_d  = ctl_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            lane_q  <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            ctl_q   <= '0;
            alu_w_q <= '0;
            rd_w_q  <= '0;
            wctl_q  <= '0;
`ifdef VMEM_LANE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            ctl_q   <= ctl_d;
            alu_w_q <= alu_w_d;
            rd_w_q  <= rd_w_d;
            wctl_q  <= wctl_d;
`ifdef VMEM_LANE_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign ALUResultW = alu_w_q;
    assign ReadDataW  = rd_w_q;
    assign RegWriteW  = wctl_q.reg_write;
    assign MemtoRegW  = wctl_q.mem_to_reg;
    assign WA3W       = wctl_q.wa3;
endmodule

// File: tb/tb_vec_mem_stage.sv
// Scoreboard bench for vec_mem_stage: a word-memory responder checks every access against
// a queue of expected transactions; W-stage results are checked against a queue of expected writebacks.
module tb_vec_mem_stage;
    localparam int L = 16;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [L-1:0][31:0]   ALUResultM, WriteDataM;
    logic                 RegWriteM, MemtoRegM, MemWriteM;
    logic [3:0]           WA3M;
`ifdef VMEM_LANE_MASK_EN
    logic [L-1:0]         LaneMaskM;
`endif
    logic                 StallM, mem_req, mem_we;
    logic [31:0]          mem_addr, mem_wdata;
    logic [31:0]          mem_rdata = '0;
    logic                 mem_ack = 1'b0;
    logic [L-1:0][31:0]   ALUResultW, ReadDataW;
    logic                 RegWriteW, MemtoRegW;
    logic [3:0]           WA3W;

    vec_mem_stage dut (
        .CLK(CLK), .RST(RST),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .WA3M(WA3M),
`ifdef VMEM_LANE_MASK_EN
        .LaneMaskM(LaneMaskM),
`endif
        .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WA3W(WA3W)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mtx_t;
    typedef struct { logic [L-1:0][31:0] alu; logic [L-1:0][31:0] rd; logic rw; logic mr; logic [3:0] wa; } wexp_t;

    mtx_t  mq[$];
    wexp_t wq[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    ack_delay = 0;
    bit    spur_en = 1'b0;
    int    wait_cnt = 0;
    int    req_cnt = 0;
    logic [31:0] held_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // memory responder: ack after ack_delay wait cycles, rdata = addr ^ 0xFFFF
    always @(negedge CLK) begin
        mtx_t t;
        if (mem_req === 1'b1 && RST === 1'b0) begin
            req_cnt++;
            if (wait_cnt == 0) held_addr = mem_addr;
            else chk("addr_stable", mem_addr, held_addr);
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 32'hFFFF;
                wait_cnt  = 0;
                chk("mq_nonempty", 32'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    t = mq.pop_front();
                    chk("mem_we", mem_we, t.we);
                    chk("mem_addr", mem_addr, t.addr);
                    if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            mem_ack   = spur_en;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt  = 0;
        end
    end

    task automatic drive_idle();
        RegWriteM = 1'b0;
        MemtoRegM = 1'b0;
        MemWriteM = 1'b0;
        WA3M      = 4'd0;
    endtask

    // called at posedge+1 with the DUT in IDLE; returns at posedge+1 after W is loaded
    task automatic run_op(input string tag, input logic [L-1:0][31:0] a, input logic [L-1:0][31:0] d,
                          input logic rw, input logic mr, input logic mw, input logic [3:0] wa,
                          input logic [L-1:0] mk);
        wexp_t e;
        int    act = 0;
        int    st = 0;
        int    rq0;
        bit    memop = mr | mw;
        e.alu = a; e.rd = '0; e.rw = rw; e.mr = mr; e.wa = wa;
        for (int i = 0; i < L; i++)
            if (memop && mk[i]) begin
                act++;
                mq.push_back('{we: mw, addr: a[i], wdata: d[i]});
                if (!mw) e.rd[i] = a[i] ^ 32'hFFFF;
            end
        wq.push_back(e);
        ALUResultM = a; WriteDataM = d;
        RegWriteM = rw; MemtoRegM = mr; MemWriteM = mw; WA3M = wa;
`ifdef VMEM_LANE_MASK_EN
        LaneMaskM = mk;
`endif
        rq0 = req_cnt;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK);
            if (!StallM) break;
            st++;
            if (st == 2) begin
                chk({tag, "_bubble_rw"}, RegWriteW, 0);
                chk({tag, "_bubble_mr"}, MemtoRegW, 0);
                chk({tag, "_bubble_wa"}, WA3W, 0);
            end
        end
        chk({tag, "_stall_cycles"}, st, memop ? 1 + act * (ack_delay + 1) : 0);
        @(posedge CLK); #1;
        drive_idle();
        e = wq.pop_front();
        for (int i = 0; i < L; i++) begin
            chk($sformatf("%s_alu%0d", tag, i), ALUResultW[i], e.alu[i]);
            chk($sformatf("%s_rd%0d", tag, i), ReadDataW[i], e.rd[i]);
        end
        chk({tag, "_rw"}, RegWriteW, e.rw);
        chk({tag, "_mr"}, MemtoRegW, e.mr);
        chk({tag, "_wa"}, WA3W, e.wa);
        chk({tag, "_req_cycles"}, req_cnt - rq0, act * (ack_delay + 1));
        chk({tag, "_mq_drained"}, mq.size(), 0);
    endtask

    initial begin
        logic [L-1:0][31:0] a, d;
        bit hit;
        RST = 1'b1;
        ALUResultM = '0; WriteDataM = '0;
        drive_idle();
`ifdef VMEM_LANE_MASK_EN
        LaneMaskM = '1;
`endif
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_stall", StallM, 0);
        chk("rst_req", mem_req, 0);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("rst_alu%0d", i), ALUResultW[i], 0);
            chk($sformatf("rst_rd%0d", i), ReadDataW[i], 0);
        end
        chk("rst_rw", RegWriteW, 0);
        chk("rst_mr", MemtoRegW, 0);
        chk("rst_wa", WA3W, 0);
        @(posedge CLK); #1;

        for (int i = 0; i < L; i++) begin a[i] = i; d[i] = 32'hFFFF_0000 + i; end
        run_op("alu", a, d, 1'b1, 1'b0, 1'b0, 4'd3, '1);

        for (int i = 0; i < L; i++) begin a[i] = 32'h100 + 4 * i; d[i] = 32'hA0 + i; end
        ack_delay = 0;
        run_op("st", a, d, 1'b0, 1'b0, 1'b1, 4'd2, '1);
        ack_delay = 2;
        run_op("ld", a, d, 1'b1, 1'b1, 1'b0, 4'd5, '1);
        ack_delay = 1;
        run_op("stld", a, d, 1'b1, 1'b1, 1'b1, 4'd7, '1);

        spur_en = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("spur_idle_req", mem_req, 0);
            chk("spur_idle_stall", StallM, 0);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < L; i++) begin a[i] = 32'h200 + 8 * i; d[i] = 32'h5A5A_0000 + i; end
        run_op("spur_ld", a, d, 1'b1, 1'b1, 1'b0, 4'd9, '1);
        spur_en = 1'b0;

`ifdef VMEM_LANE_MASK_EN
        ack_delay = 0;
        run_op("mask5", a, d, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0005);
        run_op("mask0", a, d, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0000);
`endif

        // reset while lane 5 is in flight
        ack_delay = 0;
        for (int i = 0; i < L; i++) begin
            a[i] = 32'h100 + 4 * i;
            mq.push_back('{we: 1'b0, addr: a[i], wdata: 32'h0});
        end
        ALUResultM = a; RegWriteM = 1'b1; MemtoRegM = 1'b1; WA3M = 4'd8;
`ifdef VMEM_LANE_MASK_EN
        LaneMaskM = '1;
`endif
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (mem_req === 1'b1 && mem_addr == 32'h114) begin hit = 1'b1; break; end
        end
        chk("rst_reach_lane5", 32'(hit), 1);
        #1 RST = 1'b1;
        spur_en = 1'b1;
        drive_idle();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("midrst_req", mem_req, 0);
        chk("midrst_stall", StallM, 0);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("midrst_alu%0d", i), ALUResultW[i], 0);
            chk($sformatf("midrst_rd%0d", i), ReadDataW[i], 0);
        end
        chk("midrst_rw", RegWriteW, 0);
        chk("midrst_mr", MemtoRegW, 0);
        chk("midrst_wa", WA3W, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("postrst_req", mem_req, 0);
            chk("postrst_stall", StallM, 0);
        end
        spur_en = 1'b0;
        mq.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_mem_stage.md
# vec_mem_stage

Memory stage of the vector pipeline. It sits directly downstream of the EX/MEM register, consumes its 16-lane result, write-data and control outputs, and serializes vector loads and stores onto a single 32-bit word memory port with a req/ack handshake. It stalls the upstream pipeline while lanes are in flight. It also registers the MEM/WB boundary (ALU result, gathered read data, writeback control) for the writeback stage.

## Interface
Parameters:
- LANES, 16, number of vector lanes
- DATA_W, 32, lane width and memory word width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- ALUResultM  in  [LANES][DATA_W]  per-lane result; for memory ops, per-lane byte address
- WriteDataM  in  [LANES][DATA_W]  per-lane store data
- RegWriteM  in  1  writeback enable
- MemtoRegM  in  1  load: gather LANES words
- MemWriteM  in  1  store: scatter LANES words
- WA3M  in  4  destination vector register
- StallM  out  1  hold EX/MEM and everything upstream
- mem_req  out  1  word access request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  DATA_W  word byte address
- mem_wdata  out  DATA_W  store word
- mem_rdata  in  DATA_W  load word, valid with mem_ack on a read
- mem_ack  in  1  access complete this cycle
- ALUResultW  out  [LANES][DATA_W]  registered ALU result
- ReadDataW  out  [LANES][DATA_W]  registered gathered load data
- RegWriteW, MemtoRegW  out  1 each  registered control
- WA3W  out  4  registered destination

## Operation
- Memory op = MemtoRegM | MemWriteM. If both are set, treat the op as a store; MemtoReg is still forwarded.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, non-memory op: no stall. At the edge the W registers load the M inputs, and ReadDataW loads 0.
- IDLE, memory op:
  - StallM = 1 combinationally.
  - At the edge: capture addresses, write data and op type; set lane = 0; go to ACCESS.
  - The W registers load a bubble: RegWriteW = 0, MemtoRegW = 0, WA3W = 0, data unchanged.
- ACCESS:
  - Outputs: StallM = 1, mem_req = 1, mem_addr = addr[lane], mem_we = store, mem_wdata = wdata[lane].
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack.
  - On mem_ack: a load writes mem_rdata into buffer[lane]. If lane == LANES-1, go to DONE; otherwise lane++.
  - W registers hold.
- DONE:
  - StallM = 0, mem_req = 0.
  - At the edge: the W registers load the captured control and ALUResultM. ReadDataW loads the buffer for a load, or 0 for a store. Return to IDLE.
  - Upstream advances on the same edge.
- mem_ack while mem_req = 0 is ignored.
- Lane counter is 4 bits for the default parameters (clog2(LANES)), with no wrap beyond LANES-1.
- Reset: at a rising edge with RST = 1, state = IDLE, lane = 0, and the buffer and all W outputs clear to 0. The stall and memory port outputs are 0 from the following cycle.
  - Reset mid-ACCESS abandons the op. Remaining lanes are not issued, and a late mem_ack is ignored.

## Timing
- Non-memory op: 1 cycle, M to W, no stall.
- Memory op with ack in the same cycle as req:
  - StallM is high for LANES+1 cycles (IDLE detect plus LANES ACCESS cycles).
  - W is valid LANES+2 edges after the op appears at M.
- Each extra ack wait cycle adds one stall cycle.
- Back-to-back memory ops: the second is detected in the IDLE cycle following DONE, with no lost cycle beyond DONE.

## Configuration
- VMEM_LANE_MASK_EN defined:
  - Adds input LaneMaskM [LANES], captured with the op.
  - ACCESS issues only lanes whose mask bit is 1, in ascending order. Masked lanes take no cycles and load 0 into the buffer.
  - An all-zero mask goes IDLE to DONE directly: 2-cycle op, StallM high for 1 cycle.
- Undefined: the port is absent and all LANES lanes are always accessed.

## Test plan
- Reset: hold RST for 2 cycles during ACCESS at lane 5 -> the next cycle has mem_req = 0 and StallM = 0, and all W outputs are 0.
- ALU op (ALUResultM lane i = i, RegWriteM = 1, WA3M = 3) -> the next edge gives ALUResultW lane i = i, RegWriteW = 1, WA3W = 3, StallM never high.
- Store with addresses 0x100 + 4i, data 0xA0+i, ack every cycle -> 16 writes in ascending address order, StallM high for exactly 17 cycles, RegWriteW = 0.
- Load with mem_rdata = addr ^ 0xFFFF and ack delayed 2 cycles per lane -> ReadDataW lane i = (0x100 + 4i) ^ 0xFFFF, MemtoRegW = 1, StallM high for 49 cycles, addr stable while waiting.
- Spurious mem_ack pulses in IDLE and DONE -> no state or buffer change.
- With VMEM_LANE_MASK_EN and mask 0x0005, load -> only lanes 0 and 2 are requested, other lanes read 0. With mask 0x0000 -> no mem_req, and StallM is high for 1 cycle.
